// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state encoding and small-sigma helpers
// used by the message schedule and its next-word datapath.
package sha256_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int WORD_W        = 32;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] sigma0(
        input logic [WORD_W-1:0] x
    );
        return {x[6:0], x[31:7]}
             ^ {x[17:0], x[31:18]}
             ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(
        input logic [WORD_W-1:0] x
    );
        return {x[16:0], x[31:17]}
             ^ {x[18:0], x[31:19]}
             ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational next schedule word from the four window taps:
// W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], modulo 2^32.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w14_i,
    input  logic [WORD_W-1:0] w9_i,
    input  logic [WORD_W-1:0] w1_i,
    input  logic [WORD_W-1:0] w0_i,
    output logic [WORD_W-1:0] wnext_o
);

    assign wnext_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words serially, then streams
// W[0..ROUNDS-1] from a 16-word sliding window with a valid/ready handshake.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [IDX_W-1:0]  w_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(ROUNDS - 1);

    state_e                        state_q, state_d;
    logic [3:0]                    load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0]              t_q, t_d;
    logic [15:0][WORD_W-1:0]       win_q, win_d;
    logic                          done_q, done_d;
    logic                          busy_q, busy_d;
    logic [WORD_W-1:0]             wnext;

    sha256_w_next u_w_next (
        .w14_i   (win_q[14]),
        .w9_i    (win_q[9]),
        .w1_i    (win_q[1]),
        .w0_i    (win_q[0]),
        .wnext_o (wnext)
    );

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        win_d      = win_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (m_valid) begin
                    win_d      = {m_word, win_q[15:1]};
                    load_cnt_d = load_cnt_q + 4'd1;
                    busy_d     = 1'b1;
                    if (load_cnt_q == 4'd15) begin
                        state_d    = EMIT;
                        load_cnt_d = 4'd0;
                        t_d        = '0;
                    end
                end
            end
            EMIT: begin
                if (w_ready) begin
                    // Tail-end wnext values are shifted in but never reach win[0].
                    win_d = {wnext, win_q[15:1]};
                    t_d   = t_q + IDX_W'(1);
                    if (t_q == T_LAST) begin
                        state_d    = LOAD;
                        load_cnt_d = 4'd0;
                        t_d        = '0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            load_cnt_q <= 4'd0;
            t_q        <= '0;
            win_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            win_q      <= win_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign m_ready = (state_q == LOAD);
    assign w_valid = (state_q == EMIT);
    assign w_data  = w_valid ? win_q[0] : '0;
    assign w_idx   = t_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a plain-arithmetic
// schedule-expansion model, known "abc" vectors and handshake corner cases.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        busy;
    logic        done;

    sha256_msg_schedule #(.ROUNDS(64), .IDX_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_word  (m_word),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_idx   (w_idx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] blk [2][16];
    logic [31:0] refw [64];
    logic [31:0] got [64];
    int          got_n;
    vec_t        tbl [8];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref(input int b);
        for (int t = 0; t < 16; t++) refw[t] = blk[b][t];
        for (int t = 16; t < 64; t++)
            refw[t] = ss1(refw[t-2]) + refw[t-7] + ss0(refw[t-15]) + refw[t-16];
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: timeout", nm);
    endtask

    task automatic rand_block(input int b);
        for (int i = 0; i < 16; i++) blk[b][i] = $urandom;
    endtask

    task automatic abc_block(input int b);
        for (int i = 0; i < 16; i++) blk[b][i] = 32'h0;
        blk[b][0]  = 32'h61626380;
        blk[b][15] = 32'h00000018;
    endtask

    // Called at a negedge; returns at the negedge after the 16th accept.
    task automatic load_block(input int b, input int gap);
        int n;
        for (int i = 0; i < 16; i++) begin
            if (gap > 0) begin
                m_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            m_valid = 1'b1;
            m_word  = blk[b][i];
            n = 0;
            while (!m_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!m_ready) timeout("load_wait");
            @(negedge clk);
        end
        m_valid = 1'b0;
    endtask

    task automatic collect(input int stall_pct, input int stop_at);
        int          cyc;
        bit          prev_stall;
        logic [31:0] pd;
        logic [5:0]  pi;
        got_n = 0;
        cyc = 0;
        prev_stall = 0;
        pd = '0;
        pi = '0;
        while (got_n < stop_at && cyc < 2000) begin
            chk("w_valid_emit", {31'b0, w_valid}, 32'd1);
            chk("done_early", {31'b0, done}, 32'd0);
            if (prev_stall) begin
                chk("stall_data", w_data, pd);
                chk("stall_idx", {26'b0, w_idx}, {26'b0, pi});
            end
            w_ready = ($urandom_range(99) >= stall_pct);
            if (w_ready) begin
                chk("w_idx_seq", {26'b0, w_idx}, got_n);
                got[got_n] = w_data;
                got_n++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                pd = w_data;
                pi = w_idx;
            end
            @(negedge clk);
            cyc++;
        end
        w_ready = 1'b0;
        if (got_n < stop_at) timeout("collect");
    endtask

    task automatic compare_all(input string nm);
        for (int t = 0; t < 64; t++) chk(nm, got[t], refw[t]);
    endtask

    task automatic done_checks();
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("m_ready_at_done", {31'b0, m_ready}, 32'd1);
        chk("w_valid_at_done", {31'b0, w_valid}, 32'd0);
    endtask

    task automatic done_drop();
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{0,  32'h61626380};
        tbl[1] = '{1,  32'h00000000};
        tbl[2] = '{15, 32'h00000018};
        tbl[3] = '{16, 32'h61626380};
        tbl[4] = '{17, 32'h000F0000};
        tbl[5] = '{18, 32'h7DA86405};
        tbl[6] = '{19, 32'h600003C6};
        tbl[7] = '{63, 32'h12B1EDEB};

        reset   = 1'b1;
        m_valid = 1'b0;
        m_word  = '0;
        w_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_m_ready", {31'b0, m_ready}, 32'd1);
        chk("rst_w_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_w_idx", {26'b0, w_idx}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);

        // "abc" block, free-running consumer, against fixed vectors
        abc_block(0);
        build_ref(0);
        load_block(0, 0);
        chk("busy_after_load", {31'b0, busy}, 32'd1);
        chk("w0_latency", w_data, 32'h61626380);
        collect(0, 64);
        done_checks();
        done_drop();
        for (int i = 0; i < 8; i++) chk("abc_vec", got[tbl[i].idx], tbl[i].exp);
        compare_all("abc_model");

        // "abc" with ~50% consumer stalls
        load_block(0, 0);
        collect(50, 64);
        done_checks();
        done_drop();
        compare_all("abc_stall");

        // random blocks with random stalls
        for (int r = 0; r < 3; r++) begin
            rand_block(0);
            build_ref(0);
            load_block(0, 0);
            collect(30, 64);
            done_checks();
            done_drop();
            compare_all("rand_block");
        end

        // reset in the middle of emission
        abc_block(0);
        load_block(0, 0);
        collect(0, 30);
        chk("idx_before_reset", {26'b0, w_idx}, 32'd30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_w_valid", {31'b0, w_valid}, 32'd0);
        chk("mid_rst_m_ready", {31'b0, m_ready}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_w_idx", {26'b0, w_idx}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        rand_block(0);
        build_ref(0);
        load_block(0, 0);
        collect(0, 64);
        done_checks();
        done_drop();
        compare_all("after_reset");

        // back-to-back blocks with m_valid held high
        rand_block(0);
        rand_block(1);
        build_ref(0);
        load_block(0, 0);
        m_valid = 1'b1;
        m_word  = blk[1][0];
        collect(20, 64);
        done_checks();
        compare_all("b2b_first");
        load_block(1, 0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        build_ref(1);
        collect(0, 64);
        done_checks();
        done_drop();
        compare_all("b2b_second");

        // stray message word during emission
        rand_block(0);
        build_ref(0);
        load_block(0, 0);
        m_valid = 1'b1;
        m_word  = 32'hDEADBEEF;
        collect(20, 64);
        m_valid = 1'b0;
        done_checks();
        done_drop();
        compare_all("stray_word");
        rand_block(1);
        build_ref(1);
        load_block(1, 0);
        collect(0, 64);
        done_checks();
        done_drop();
        compare_all("after_stray");

        // sparse message words: one per three cycles
        rand_block(0);
        build_ref(0);
        load_block(0, 2);
        collect(0, 64);
        done_checks();
        done_drop();
        compare_all("load_gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
